// File: rtl/clk_phase_sched_if.sv
// Request/enable bundle between the phase scheduler and its requesters/ICG consumers.
interface clk_phase_sched_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rel;
    logic [NUM_REQ-1:0] en;
    logic [IDW-1:0]     gnt_id;
    logic               gnt_vld;
    logic               busy;

    modport master (output req, rel, input en, gnt_id, gnt_vld, busy);
    modport slave  (input req, rel, output en, gnt_id, gnt_vld, busy);
endinterface

// File: rtl/clk_phase_sched.sv
// Round-robin non-overlapping clock-enable phase scheduler with guard gaps.
// Optional CLK_SCHED_PRIO_EN: requester 0 becomes high priority and preempts other windows.
module clk_phase_lane (
    input  logic clk_in,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    input  logic req,
    input  logic rel,
    output logic en,
    output logic drop
);
    always_ff @(posedge clk_in) begin
        if (!reset_n)  en <= 1'b0;
        else if (set)  en <= 1'b1;
        else if (clr)  en <= 1'b0;
    end

    // Only the lane holding the window can raise drop, so rel/req of idle lanes are ignored.
    assign drop = en & (rel | ~req);
endmodule

module clk_phase_sched #(
    parameter int NUM_REQ      = 4,
    parameter int SLOT_CYCLES  = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    clk_phase_sched_if.slave  bus
);
    localparam int IDW = $clog2(NUM_REQ);

    if (GUARD_CYCLES < 1 || GUARD_CYCLES > 15) begin : g_bad_guard
        $fatal(1, "clk_phase_sched: GUARD_CYCLES must be 1..15");
    end
    if (SLOT_CYCLES < 1 || SLOT_CYCLES > 255) begin : g_bad_slot
        $fatal(1, "clk_phase_sched: SLOT_CYCLES must be 1..255");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num
        $fatal(1, "clk_phase_sched: NUM_REQ must be 2..16");
    end

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, GUARD = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [7:0]         slot_cnt, slot_nxt;
    logic [3:0]         guard_cnt, guard_nxt;
    logic [IDW-1:0]     rr_ptr, ptr_nxt;
    logic [IDW-1:0]     gid_q, gid_nxt;
    logic               vld_q, vld_nxt;
    logic               busy_q;
    logic [NUM_REQ-1:0] grant, drop;
    logic               kill, do_arb, win_exit, prio_kill;
    logic               any_req, prio_win;
    logic [IDW-1:0]     win;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] p, input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDW-1:0];
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        clk_phase_lane u_lane (
            .clk_in  (clk_in),
            .reset_n (reset_n),
            .set     (grant[i]),
            .clr     (kill),
            .req     (bus.req[i]),
            .rel     (bus.rel[i]),
            .en      (bus.en[i]),
            .drop    (drop[i])
        );
    end

    // First set request at or after rr_ptr, wrapping.
    always_comb begin
        any_req  = 1'b0;
        win      = '0;
        prio_win = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_req && bus.req[wrap_add(rr_ptr, i)]) begin
                any_req = 1'b1;
                win     = wrap_add(rr_ptr, i);
            end
        end
`ifdef CLK_SCHED_PRIO_EN
        if (bus.req[0]) begin
            win      = '0;
            prio_win = 1'b1;
        end
`endif
    end

`ifdef CLK_SCHED_PRIO_EN
    assign prio_kill = bus.req[0] & (gid_q != '0);
`else
    assign prio_kill = 1'b0;
`endif

    assign win_exit = (slot_cnt == 8'd0) | (|drop) | prio_kill;

    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_cnt;
        guard_nxt = guard_cnt;
        ptr_nxt   = rr_ptr;
        gid_nxt   = gid_q;
        vld_nxt   = 1'b0;
        grant     = '0;
        kill      = 1'b0;
        do_arb    = 1'b0;
        unique case (state)
            IDLE: do_arb = 1'b1;
            ACTIVE: begin
                if (win_exit) begin
                    state_nxt = GUARD;
                    kill      = 1'b1;
                    guard_nxt = 4'(GUARD_CYCLES - 1);
                end else begin
                    slot_nxt = slot_cnt - 8'd1;
                end
            end
            GUARD: begin
                if (guard_cnt != 4'd0) begin
                    guard_nxt = guard_cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                    do_arb    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Arbitrating straight out of GUARD keeps the en gap at exactly GUARD_CYCLES.
        if (do_arb && any_req) begin
            state_nxt  = ACTIVE;
            grant[win] = 1'b1;
            gid_nxt    = win;
            vld_nxt    = 1'b1;
            slot_nxt   = 8'(SLOT_CYCLES - 1);
            ptr_nxt    = prio_win ? rr_ptr : wrap_add(win, 1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state     <= IDLE;
            slot_cnt  <= 8'd0;
            guard_cnt <= 4'd0;
            rr_ptr    <= '0;
            gid_q     <= '0;
            vld_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            slot_cnt  <= slot_nxt;
            guard_cnt <= guard_nxt;
            rr_ptr    <= ptr_nxt;
            gid_q     <= gid_nxt;
            vld_q     <= vld_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.gnt_id  = gid_q;
    assign bus.gnt_vld = vld_q;
    assign bus.busy    = busy_q;

    a_onehot: assert property (@(posedge clk_in) $onehot0(bus.en));
    a_en_active: assert property (@(posedge clk_in) (|bus.en) |-> (state == ACTIVE));
    a_no_handover: assert property (@(posedge clk_in)
        ((|bus.en) && (|$past(bus.en))) |-> (bus.en == $past(bus.en)));
endmodule

// File: tb/tb_clk_phase_sched.sv
// Directed plus random bench for clk_phase_sched against a window-level reference model.
module tb_clk_phase_sched;
    localparam int N    = 4;
    localparam int SLOT = 4;

    typedef struct {
        int owner;  // -1 when no window is open
        int len;    // en cycles already given to owner
        int gap;    // guard cycles remaining, current one included
        int ptr;
        int gid;
        bit vld;
    } mdl_t;

    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_in = ~clk_in;

    clk_phase_sched_if #(.NUM_REQ(N)) bus();
    clk_phase_sched_if #(.NUM_REQ(N)) bus3();

    clk_phase_sched #(.NUM_REQ(N), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(1)) dut (
        .clk_in(clk_in), .reset_n(reset_n), .bus(bus.slave));
    clk_phase_sched #(.NUM_REQ(N), .SLOT_CYCLES(SLOT), .GUARD_CYCLES(3)) dut3 (
        .clk_in(clk_in), .reset_n(reset_n), .bus(bus3.slave));

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    mdl_t m, m3;
    int   vld_id[$], vld_cyc[$], lens[$], vld3_cyc[$], lens3[$];
    int   run = 0, run3 = 0;

    function automatic mdl_t mstep(mdl_t c, bit rn, logic [N-1:0] rq, logic [N-1:0] rl, int g);
        mdl_t n;
        bit   stop;
        n     = c;
        n.vld = 1'b0;
        if (!rn) begin
            n.owner = -1; n.len = 0; n.gap = 0; n.ptr = 0; n.gid = 0;
            return n;
        end
        if (c.owner >= 0) begin
            stop = (c.len == SLOT) || rl[c.owner] || !rq[c.owner];
`ifdef CLK_SCHED_PRIO_EN
            if (c.owner != 0 && rq[0]) stop = 1'b1;
`endif
            if (stop) begin
                n.owner = -1;
                n.gap   = g;
            end else begin
                n.len = c.len + 1;
            end
            return n;
        end
        if (c.gap > 1) begin
            n.gap = c.gap - 1;
            return n;
        end
        n.gap = 0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = (c.ptr + i) % N;
            if (n.owner < 0 && rq[k]) begin
                n.owner = k;
                n.ptr   = (k + 1) % N;
            end
        end
`ifdef CLK_SCHED_PRIO_EN
        if (rq[0]) begin
            n.owner = 0;
            n.ptr   = c.ptr;
        end
`endif
        if (n.owner >= 0) begin
            n.len = 1;
            n.gid = n.owner;
            n.vld = 1'b1;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_en(mdl_t c);
        return (c.owner >= 0) ? (32'd1 << c.owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_busy(mdl_t c);
        return (c.owner >= 0 || c.gap > 0) ? 32'd1 : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic clear_rec();
        vld_id.delete(); vld_cyc.delete(); lens.delete();
        vld3_cyc.delete(); lens3.delete();
        run = 0; run3 = 0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        m  = mstep(m,  reset_n, bus.req,  bus.rel,  1);
        m3 = mstep(m3, reset_n, bus3.req, bus3.rel, 3);
        #1;
        cyc++;
        chk("en",       32'(bus.en),       exp_en(m));
        chk("gnt_id",   32'(bus.gnt_id),   m.gid);
        chk("gnt_vld",  32'(bus.gnt_vld),  32'(m.vld));
        chk("busy",     32'(bus.busy),     exp_busy(m));
        chk("en_g3",    32'(bus3.en),      exp_en(m3));
        chk("gnt_id_g3",32'(bus3.gnt_id),  m3.gid);
        chk("vld_g3",   32'(bus3.gnt_vld), 32'(m3.vld));
        chk("busy_g3",  32'(bus3.busy),    exp_busy(m3));
        if (bus.gnt_vld) begin
            vld_id.push_back(int'(bus.gnt_id));
            vld_cyc.push_back(cyc);
        end
        if (bus3.gnt_vld) vld3_cyc.push_back(cyc);
        if (bus.en != '0) run++;
        else if (run > 0) begin lens.push_back(run); run = 0; end
        if (bus3.en != '0) run3++;
        else if (run3 > 0) begin lens3.push_back(run3); run3 = 0; end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.req = '0; bus.rel = '0;
        tick();
        reset_n = 1'b1;
        clear_rec();
    endtask

    initial begin
        logic [N-1:0] rq, rq3;
        m  = mstep(m,  1'b0, '0, '0, 1);
        m3 = mstep(m3, 1'b0, '0, '0, 3);
        bus.req = '0; bus.rel = '0; bus3.req = '0; bus3.rel = '0;

        // reset held with all requesters asking
        reset_n  = 1'b0;
        bus.req  = 4'b1111;
        bus3.req = 4'b1000;
        tick();
        tick();
        chk("rst_en",     32'(bus.en),      0);
        chk("rst_busy",   32'(bus.busy),    0);
        chk("rst_vld",    32'(bus.gnt_vld), 0);
        chk("rst_gnt_id", 32'(bus.gnt_id),  0);
        chk("rst_ptr",    32'(dut.rr_ptr),  0);

        // full round robin; sole requester on the guard=3 instance
        clear_rec();
        reset_n = 1'b1;
        repeat (21) tick();
`ifndef CLK_SCHED_PRIO_EN
        chk("rr_count", vld_id.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", vld_id[i], i % 4);
        for (int i = 1; i < 5; i++) chk("rr_spacing", vld_cyc[i] - vld_cyc[i-1], 5);
        for (int i = 0; i < 4; i++) chk("rr_len", lens[i], 4);
`endif
        chk("sole_count", vld3_cyc.size(), 3);
        for (int i = 1; i < 3; i++) chk("sole_spacing", vld3_cyc[i] - vld3_cyc[i-1], 7);
        for (int i = 0; i < 2; i++) chk("sole_len", lens3[i], 4);
        chk("sole_gnt_id", 32'(bus3.gnt_id), 3);

        // early release of id1, req drop of id2
        do_reset();
        bus.req = 4'b0110;
        tick();
        tick();
        bus.rel = 4'b0010;
        tick();
        bus.rel = 4'b0000;
        tick();
        tick();
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick();
        tick();
        chk("rel_count", vld_id.size(), 2);
        chk("rel_id0",   vld_id[0], 1);
        chk("rel_id1",   vld_id[1], 2);
        chk("rel_len0",  lens[0], 2);
        chk("rel_len1",  lens[1], 2);

        // reset in the third cycle of id2's window
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        tick();
        chk("pre_rst_en", 32'(bus.en), 32'h4);
        reset_n = 1'b0;
        bus.req = 4'b0110;
        tick();
        chk("mid_rst_en",    32'(bus.en),    0);
        chk("mid_rst_busy",  32'(bus.busy),  0);
        chk("mid_rst_state", 32'(dut.state), 0);
        chk("mid_rst_ptr",   32'(dut.rr_ptr), 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_id", 32'(bus.gnt_id), 1);
        chk("post_rst_en", 32'(bus.en), 32'h2);

`ifdef CLK_SCHED_PRIO_EN
        // requester 0 preempts id2 in its second cycle
        do_reset();
        bus.req = 4'b0100;
        tick();
        tick();
        bus.req = 4'b0101;
        tick();
        chk("prio_guard_en", 32'(bus.en), 0);
        tick();
        chk("prio_en",   32'(bus.en), 32'h1);
        chk("prio_len",  lens[0], 2);
        chk("prio_ptr",  32'(dut.rr_ptr), 3);
        bus.req = 4'b0000;
        tick();
`endif

        // random traffic with occasional resets
        do_reset();
        rq  = '0;
        rq3 = '0;
        for (int k = 0; k < 600; k++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 5) == 0) rq[b]  = ~rq[b];
                if ($urandom_range(0, 5) == 0) rq3[b] = ~rq3[b];
            end
            bus.req  = rq;
            bus.rel  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            bus3.req = rq3;
            bus3.rel = 4'($urandom) & 4'($urandom) & 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
